regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port register file; next generation of the 32x32 three-read-port register file.
- Adds the following over that block:
  - configurable width, depth and read-port count;
  - a second write port with fixed priority;
  - asynchronous clear;
  - optional write-to-read bypass;
  - a per-register busy scoreboard, so the pipeline can detect pending producers.
- Sits between decode (reads and reservations) and writeback (two write ports) in the datapath.

Parameters:
- DATA_W, 32, bits per register.
- DEPTH, 32, number of registers; must be a power of two, at least 2.
- ADDR_W, $clog2(DEPTH), register address width.
- NUM_RD, 3, number of read ports (1..4).
- ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and is never busy.
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- we0  in  1  write port 0 enable.
- wa0  in  ADDR_W  write port 0 address.
- wd0  in  DATA_W  write port 0 data.
- we1  in  1  write port 1 enable (higher priority).
- wa1  in  ADDR_W  write port 1 address.
- wd1  in  DATA_W  write port 1 data.
- rsv_en  in  1  reserve request: mark register rsv_addr busy.
- rsv_addr  in  ADDR_W  register to reserve.
- ra  in  NUM_RD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W].
- rd  out  NUM_RD*DATA_W  read data; port i at bits [i*DATA_W +: DATA_W].
- rbusy  out  NUM_RD  busy flag of the register addressed by each read port.
- busy_vec  out  DEPTH  full scoreboard, bit n = register n busy.

Behaviour:
- Reset (reset_n low, asynchronous, takes effect immediately):
  - all registers cleared to 0; all busy bits cleared to 0.
  - rd, rbusy and busy_vec are therefore all 0 while reset is held.
  - writes and reservations are ignored while reset_n is low.
  - on deassertion, the first capture is on the next rising edge.
- Write, at rising edge:
  - if weN, mem[waN] <= wdN.
  - we0 and we1 to the same address: port 1 value stored, port 0 value discarded.
  - ZERO_REG=1: writes to address 0 are dropped.
  - out-of-range addresses cannot occur (DEPTH is a power of two).
- Read: combinational, zero latency, per port i.
  - ZERO_REG=1 and ra_i==0 -> rd_i = 0.
  - else BYPASS=1 and we1 and wa1==ra_i -> rd_i = wd1.
  - else BYPASS=1 and we0 and wa0==ra_i -> rd_i = wd0.
  - else rd_i = mem[ra_i].
  - BYPASS=0: rd_i shows the new value starting the cycle after the write edge.
- Scoreboard, at rising edge, per register n:
  - cleared if (we0 and wa0==n) or (we1 and wa1==n).
  - set if rsv_en and rsv_addr==n.
  - set takes priority over clear when both occur in the same cycle (a new producer overrides the retiring one).
  - ZERO_REG=1: busy[0] is held at 0 and reserving address 0 is ignored.
  - writing a non-busy register is legal and leaves its busy bit 0.
- rbusy_i:
  - equals busy[ra_i];
  - BYPASS=1: forced 0 when a same-cycle write hits ra_i (data already forwarded), unless ZERO_REG makes the address 0.
- Multiple read ports may use the same address; each returns identical data.

Test Plan:
- Reset clears state:
  - stimulus: write 0xDEADBEEF to r5 with we0, then pulse reset_n low mid-cycle for 3 ns (async);
  - required: rd for ra=5 reads 0 immediately, and busy_vec==0.
- Sequential writes then reads:
  - stimulus: we0 writes 20,21,...,50 to r1..r31 on consecutive edges; then ra0=1, ra1=31, ra2=0;
  - required: rd0=20, rd1=50, rd2=0; a write of 7 to r0 still reads 0.
- Write collision:
  - stimulus: same edge, we0 writes 0x11 to r9 and we1 writes 0x22 to r9;
  - required: next cycle r9 reads 0x22.
- Bypass:
  - stimulus: BYPASS=1, we1 writes 0xABCD to r4 with ra0=4 in the same cycle;
  - required: rd0=0xABCD before the edge, rbusy0=0;
  - with BYPASS=0, the same stimulus gives rd0=old value until after the edge.
- Scoreboard:
  - stimulus: rsv r7 -> busy_vec[7]=1 next cycle and rbusy=1 for ra=7; then write r7 -> busy clears after the edge;
  - stimulus: rsv r7 and write r7 on the same edge -> busy_vec[7] stays 1;
  - stimulus: rsv r0 -> busy_vec[0] stays 0.
- Parameter sweep:
  - stimulus: DATA_W=16, DEPTH=8, NUM_RD=2, ZERO_REG=0;
  - required: write 0xFFFF to r0 -> reads 0xFFFF; addresses wrap within 3 bits; both ports read independently.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp -- parametrised multi-port register file with busy scoreboard.
//
// Purpose:
//   Register file between decode (reads, reservations) and writeback (two
//   write ports). Reads are combinational and can optionally forward
//   same-cycle write data. A per-register busy bit marks registers that still
//   have a producer in flight.
//
// Ports:
//   clock     in   single clock, all state updates on the rising edge
//   reset_n   in   asynchronous active-low reset; clears registers and busy bits
//   we0/wa0/wd0   write port 0 (lower priority)
//   we1/wa1/wd1   write port 1 (wins on an address collision)
//   rsv_en/rsv_addr  mark a register busy at the next edge
//   ra        in   NUM_RD packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd        out  NUM_RD packed read data,   port i at [i*DATA_W +: DATA_W]
//   rbusy     out  busy flag of the register each read port addresses
//   busy_vec  out  full scoreboard, bit n = register n busy
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int NUM_RD   = 3,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] rd,
  output logic [NUM_RD-1:0]        rbusy,
  output logic [DEPTH-1:0]         busy_vec
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;

  // Requests are qualified with reset_n so that, while reset is held, the
  // bypass path cannot forward write data and the outputs stay at zero.
  logic wr0_en;
  logic wr1_en;
  logic rsv_ok;

  assign wr0_en = we0 & reset_n;
  assign wr1_en = we1 & reset_n;
  assign rsv_ok = rsv_en & reset_n;

  // Next state: port 1 is applied after port 0 so it wins on a collision;
  // a reservation is applied after the write clears so a new producer
  // overrides the retiring one.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    if (wr0_en) begin
      mem_d[wa0]  = wd0;
      busy_d[wa0] = 1'b0;
    end
    if (wr1_en) begin
      mem_d[wa1]  = wd1;
      busy_d[wa1] = 1'b0;
    end
    if (rsv_ok) begin
      busy_d[rsv_addr] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      mem_d[0]  = '0;
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < DEPTH; n++) begin
        mem_q[n] <= '0;
      end
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

  // Read ports: combinational, with optional forwarding of this cycle's
  // write data. A forwarded value is already the producer's result, so the
  // register is reported not busy.
  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] ra_g;
      logic [DATA_W-1:0] rd_g;
      logic              rb_g;
      logic              hit0;
      logic              hit1;

      assign ra_g = ra[gi*ADDR_W +: ADDR_W];
      assign hit0 = wr0_en && (wa0 == ra_g);
      assign hit1 = wr1_en && (wa1 == ra_g);

      always_comb begin
        rd_g = mem_q[ra_g];
        rb_g = busy_q[ra_g];
        if (BYPASS != 0) begin
          if (hit1) begin
            rd_g = wd1;
            rb_g = 1'b0;
          end else if (hit0) begin
            rd_g = wd0;
            rb_g = 1'b0;
          end
        end
        if ((ZERO_REG != 0) && (ra_g == '0)) begin
          rd_g = '0;
          rb_g = 1'b0;
        end
      end

      assign rd[gi*DATA_W +: DATA_W] = rd_g;
      assign rbusy[gi]               = rb_g;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp: three instances (default, no-bypass sharing the
// default's inputs, and a small 16x8 two-port ZERO_REG=0 variant).
// Stimulus pushes expected values into a scoreboard queue; a monitor on the
// falling edge pops every entry queued for the cycle and compares.
module tb_regfile_mp;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_n;

  // Shared inputs for the default and no-bypass instances.
  logic        we0, we1, rsv_en;
  logic [4:0]  wa0, wa1, rsv_addr;
  logic [31:0] wd0, wd1;
  logic [4:0]  ra_a [3];
  logic [14:0] ra;
  assign ra = {ra_a[2], ra_a[1], ra_a[0]};

  logic [95:0] rd_m, rd_n;
  logic [2:0]  rb_m, rb_n;
  logic [31:0] bv_m, bv_n;

  // Small instance inputs/outputs.
  logic        s_we0, s_we1, s_rsv_en;
  logic [2:0]  s_wa0, s_wa1, s_rsv_addr;
  logic [15:0] s_wd0, s_wd1;
  logic [2:0]  s_ra_a [2];
  logic [5:0]  s_ra;
  assign s_ra = {s_ra_a[1], s_ra_a[0]};
  logic [31:0] s_rd;
  logic [1:0]  s_rb;
  logic [7:0]  s_bv;

  regfile_mp u_dut (
    .clock(clock), .reset_n(reset_n),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .ra(ra), .rd(rd_m), .rbusy(rb_m), .busy_vec(bv_m)
  );

  regfile_mp #(.BYPASS(0)) u_nb (
    .clock(clock), .reset_n(reset_n),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .ra(ra), .rd(rd_n), .rbusy(rb_n), .busy_vec(bv_n)
  );

  regfile_mp #(.DATA_W(16), .DEPTH(8), .NUM_RD(2), .ZERO_REG(0)) u_sm (
    .clock(clock), .reset_n(reset_n),
    .we0(s_we0), .wa0(s_wa0), .wd0(s_wd0),
    .we1(s_we1), .wa1(s_wa1), .wd1(s_wd1),
    .rsv_en(s_rsv_en), .rsv_addr(s_rsv_addr),
    .ra(s_ra), .rd(s_rd), .rbusy(s_rb), .busy_vec(s_bv)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [127:0] name;
    logic [1:0]   inst;   // 0 default, 1 no-bypass, 2 small
    logic [1:0]   kind;   // 0 rd, 1 rbusy, 2 busy_vec
    logic [1:0]   port;
    logic [63:0]  exp;
  } exp_t;

  exp_t sb_q [$];
  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;

  task automatic push(input logic [127:0] nm, input int inst, input int kind,
                      input int port, input logic [63:0] e);
    exp_t x;
    x.name = nm;
    x.inst = inst[1:0];
    x.kind = kind[1:0];
    x.port = port[1:0];
    x.exp  = e;
    sb_q.push_back(x);
  endtask

  function automatic logic [63:0] actual(input exp_t x);
    logic [63:0] v;
    int p;
    p = int'(x.port);
    v = '0;
    case (x.inst)
      2'd0: case (x.kind)
              2'd0: v = {32'h0, rd_m[p*32 +: 32]};
              2'd1: v = {63'h0, rb_m[p]};
              default: v = {32'h0, bv_m};
            endcase
      2'd1: case (x.kind)
              2'd0: v = {32'h0, rd_n[p*32 +: 32]};
              2'd1: v = {63'h0, rb_n[p]};
              default: v = {32'h0, bv_n};
            endcase
      default: case (x.kind)
              2'd0: v = {48'h0, s_rd[p*16 +: 16]};
              2'd1: v = {63'h0, s_rb[p]};
              default: v = {56'h0, s_bv};
            endcase
    endcase
    return v;
  endfunction

  always @(negedge clock) begin
    while (sb_q.size() > 0) begin
      exp_t x;
      logic [63:0] a;
      x = sb_q.pop_front();
      a = actual(x);
      checks++;
      if (a !== x.exp) begin
        errors++;
        $display("FAIL %0s inst=%0d port=%0d actual=%h required=%h",
                 x.name, x.inst, x.port, a, x.exp);
      end
    end
  end

  // ---------------- reference model (default-size file) ----------------
  logic [31:0] m_mem  [32];
  logic        m_busy [32];

  task automatic model_clear();
    for (int n = 0; n < 32; n++) begin
      m_mem[n]  = '0;
      m_busy[n] = 1'b0;
    end
  endtask

  // A same-cycle write is visible on a read port only when forwarding is on;
  // port 1 is the newer value on a collision. Register 0 is always zero.
  function automatic logic [31:0] exp_rd(input int p, input bit byp);
    logic [4:0] a;
    a = ra_a[p];
    if (a == 5'd0) return 32'h0;
    if (byp && we1 && (wa1 == a)) return wd1;
    if (byp && we0 && (wa0 == a)) return wd0;
    return m_mem[a];
  endfunction

  function automatic logic exp_rb(input int p, input bit byp);
    logic [4:0] a;
    a = ra_a[p];
    if (a == 5'd0) return 1'b0;
    if (byp && ((we1 && (wa1 == a)) || (we0 && (wa0 == a)))) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic [31:0] exp_bv();
    logic [31:0] v;
    for (int n = 0; n < 32; n++) v[n] = m_busy[n];
    return v;
  endfunction

  task automatic idle();
    we0 = 0; we1 = 0; rsv_en = 0;
    wa0 = 0; wa1 = 0; rsv_addr = 0; wd0 = 0; wd1 = 0;
    ra_a[0] = 0; ra_a[1] = 0; ra_a[2] = 0;
    s_we0 = 0; s_we1 = 0; s_rsv_en = 0;
    s_wa0 = 0; s_wa1 = 0; s_rsv_addr = 0; s_wd0 = 0; s_wd1 = 0;
    s_ra_a[0] = 0; s_ra_a[1] = 0;
  endtask

  // One clock: queue model expectations for the current inputs, take the
  // edge, then advance the model with the register file's update rules.
  task automatic step();
    for (int p = 0; p < 3; p++) begin
      push("rd", 0, 0, p, {32'h0, exp_rd(p, 1'b1)});
      push("rbusy", 0, 1, p, {63'h0, exp_rb(p, 1'b1)});
      push("rd_nobyp", 1, 0, p, {32'h0, exp_rd(p, 1'b0)});
      push("rbusy_nobyp", 1, 1, p, {63'h0, exp_rb(p, 1'b0)});
    end
    push("busy_vec", 0, 2, 0, {32'h0, exp_bv()});
    push("busy_vec_nobyp", 1, 2, 0, {32'h0, exp_bv()});
    $display("txn %0d we0=%b wa0=%0d wd0=%h we1=%b wa1=%0d wd1=%h rsv=%b/%0d ra=%0d,%0d,%0d",
             txn, we0, wa0, wd0, we1, wa1, wd1, rsv_en, rsv_addr,
             ra_a[0], ra_a[1], ra_a[2]);
    txn++;
    @(posedge clock);
    if (we0 && wa0 != 0) m_mem[wa0] = wd0;
    if (we1 && wa1 != 0) m_mem[wa1] = wd1;
    if (we0) m_busy[wa0] = 1'b0;
    if (we1) m_busy[wa1] = 1'b0;
    if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
    #1;
  endtask

  logic [3:0] nine;

  initial begin
    nine = 4'd9;
    reset_n = 1'b0;
    idle();
    model_clear();

    // Reset held: writes, reservations and forwarding are all suppressed.
    we0 = 1; wa0 = 5'd3; wd0 = 32'hCAFE0003; ra_a[0] = 5'd3;
    rsv_en = 1; rsv_addr = 5'd6;
    push("rst_rd", 0, 0, 0, 64'h0);
    push("rst_busy_vec", 0, 2, 0, 64'h0);
    push("rst_rd_nobyp", 1, 0, 0, 64'h0);
    push("rst_small_bv", 2, 2, 0, 64'h0);
    @(negedge clock);
    #2;
    reset_n = 1'b1;
    idle();
    @(posedge clock);
    #1;

    // Small instance: r0 is an ordinary register, addresses wrap in 3 bits.
    s_we0 = 1; s_wa0 = 3'd0; s_wd0 = 16'hFFFF;
    s_we1 = 1; s_wa1 = nine[2:0]; s_wd1 = 16'h5A5A;
    s_rsv_en = 1; s_rsv_addr = 3'd0;
    s_ra_a[0] = 3'd2; s_ra_a[1] = 3'd3;
    push("sm_rd_before", 2, 0, 0, 64'h0);
    step();
    idle();
    s_ra_a[0] = 3'd0; s_ra_a[1] = nine[2:0];
    s_we0 = 1; s_wa0 = 3'd7; s_wd0 = 16'h1357;
    push("sm_r0", 2, 0, 0, 64'hFFFF);
    push("sm_wrap", 2, 0, 1, 64'h5A5A);
    push("sm_bv", 2, 2, 0, 64'h01);
    push("sm_rbusy_r0", 2, 1, 0, 64'h1);
    step();
    idle();
    s_ra_a[0] = 3'd7; s_ra_a[1] = 3'd1;
    push("sm_r7", 2, 0, 0, 64'h1357);
    push("sm_r1", 2, 0, 1, 64'h5A5A);
    push("sm_rbusy_r7", 2, 1, 0, 64'h0);
    step();

    // Sequential writes 20..50 into r1..r31.
    for (int i = 1; i < 32; i++) begin
      idle();
      we0 = 1; wa0 = 5'(i); wd0 = 32'(19 + i);
      ra_a[0] = 5'($urandom_range(0, 31));
      step();
    end
    idle();
    ra_a[0] = 5'd1; ra_a[1] = 5'd31; ra_a[2] = 5'd0;
    push("seq_r1", 0, 0, 0, 64'd20);
    push("seq_r31", 0, 0, 1, 64'd50);
    push("seq_r0", 0, 0, 2, 64'd0);
    step();
    idle();
    we0 = 1; wa0 = 5'd0; wd0 = 32'd7;
    push("r0_bypass", 0, 0, 0, 64'd0);
    step();
    idle();
    push("r0_after", 0, 0, 0, 64'd0);
    step();

    // Collision on r9: port 1 wins.
    idle();
    we0 = 1; wa0 = 5'd9; wd0 = 32'h11;
    we1 = 1; wa1 = 5'd9; wd1 = 32'h22;
    ra_a[0] = 5'd1;
    step();
    idle();
    ra_a[0] = 5'd9;
    push("collide", 0, 0, 0, 64'h22);
    push("collide_nobyp", 1, 0, 0, 64'h22);
    step();

    // Bypass on a busy register.
    idle();
    we0 = 1; wa0 = 5'd4; wd0 = 32'h1234;
    step();
    idle();
    rsv_en = 1; rsv_addr = 5'd4;
    step();
    idle();
    we1 = 1; wa1 = 5'd4; wd1 = 32'hABCD; ra_a[0] = 5'd4;
    push("byp_rd", 0, 0, 0, 64'hABCD);
    push("byp_rbusy", 0, 1, 0, 64'h0);
    push("nobyp_rd_old", 1, 0, 0, 64'h1234);
    push("nobyp_rbusy", 1, 1, 0, 64'h1);
    step();
    idle();
    ra_a[0] = 5'd4;
    push("nobyp_rd_new", 1, 0, 0, 64'hABCD);
    push("nobyp_rbusy_clr", 1, 1, 0, 64'h0);
    step();

    // Scoreboard set, clear, set-over-clear, r0 never busy.
    idle();
    rsv_en = 1; rsv_addr = 5'd7;
    step();
    idle();
    ra_a[0] = 5'd7;
    push("rsv_bv", 0, 2, 0, 64'h80);
    push("rsv_rbusy", 0, 1, 0, 64'h1);
    step();
    idle();
    we0 = 1; wa0 = 5'd7; wd0 = 32'h77; ra_a[0] = 5'd7;
    push("wr_rbusy_byp", 0, 1, 0, 64'h0);
    push("wr_rbusy_nobyp", 1, 1, 0, 64'h1);
    step();
    idle();
    push("clr_bv", 0, 2, 0, 64'h0);
    step();
    idle();
    rsv_en = 1; rsv_addr = 5'd7; we0 = 1; wa0 = 5'd7; wd0 = 32'h78;
    step();
    idle();
    rsv_en = 1; rsv_addr = 5'd0;
    push("set_over_clr", 0, 2, 0, 64'h80);
    step();
    idle();
    push("r0_not_busy", 0, 2, 0, 64'h80);
    step();
    idle();
    we1 = 1; wa1 = 5'd7; wd1 = 32'h79;
    step();

    // Asynchronous reset mid-cycle.
    idle();
    we0 = 1; wa0 = 5'd5; wd0 = 32'hDEADBEEF;
    rsv_en = 1; rsv_addr = 5'd9;
    step();
    idle();
    ra_a[0] = 5'd5;
    push("pre_rst_r5", 0, 0, 0, 64'hDEADBEEF);
    step();
    idle();
    ra_a[0] = 5'd5;
    push("async_rst_rd", 0, 0, 0, 64'h0);
    push("async_rst_bv", 0, 2, 0, 64'h0);
    push("async_rst_rd_nobyp", 1, 0, 0, 64'h0);
    #2;
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
    model_clear();
    @(posedge clock);
    #1;
    idle();
    ra_a[0] = 5'd5; ra_a[1] = 5'd9;
    step();

    // Randomised traffic against the model.
    for (int i = 0; i < 300; i++) begin
      idle();
      we0 = 1'($urandom_range(0, 1));
      we1 = 1'($urandom_range(0, 1));
      rsv_en = 1'($urandom_range(0, 1));
      wa0 = 5'($urandom_range(0, 31));
      wa1 = ($urandom_range(0, 3) == 0) ? wa0 : 5'($urandom_range(0, 31));
      rsv_addr = ($urandom_range(0, 3) == 0) ? wa0 : 5'($urandom_range(0, 31));
      wd0 = $urandom;
      wd1 = $urandom;
      for (int p = 0; p < 3; p++) begin
        ra_a[p] = ($urandom_range(0, 2) == 0) ? wa1 : 5'($urandom_range(0, 31));
      end
      step();
    end

    idle();
    @(negedge clock);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
